// File: rtl/fractal_sync_nd_rf.sv
// Barrier-synchronisation register file: directly indexed local registers plus a
// small CAM of remote {level,id} lines, with same-cycle collision arbitration.
module fractal_sync_nd_rf #(
  parameter int N_PORTS        = 4,
  parameter int N_LOCAL_REGS   = 4,
  parameter int N_REMOTE_LINES = 4,
  parameter int LEVEL_WIDTH    = 2,
  parameter int ID_WIDTH       = 2,
  parameter int SD_WIDTH       = 2,
  parameter int EN_REMOTE      = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  logic [LEVEL_WIDTH-1:0]                level_i          [N_PORTS],
  input  logic [ID_WIDTH-1:0]                   id_i             [N_PORTS],
  input  logic                                  check_local_i    [N_PORTS],
  input  logic                                  check_remote_i   [N_PORTS],
  input  logic [SD_WIDTH-1:0]                   sd_i             [N_PORTS],
  output logic                                  valid_o          [N_PORTS],
  output logic                                  present_local_o  [N_PORTS],
  output logic                                  present_remote_o [N_PORTS],
  output logic [SD_WIDTH-1:0]                   sd_o             [N_PORTS],
  output logic                                  id_err_o         [N_PORTS],
  output logic                                  ovf_err_o        [N_PORTS],
  output logic                                  bypass_o         [N_PORTS],
  output logic                                  ignore_o         [N_PORTS],
  output logic                                  timeout_o,
  output logic [$clog2(N_REMOTE_LINES+1)-1:0]   remote_occ_o
);

  localparam int KEY_W = LEVEL_WIDTH + ID_WIDTH;
  localparam int OCC_W = $clog2(N_REMOTE_LINES + 1);
  localparam int AGE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [N_LOCAL_REGS-1:0]   r_reg_vld, w_reg_vld_n;
  logic [SD_WIDTH-1:0]       r_reg_sd [N_LOCAL_REGS];
  logic [SD_WIDTH-1:0]       w_reg_sd_n [N_LOCAL_REGS];
  logic [N_REMOTE_LINES-1:0] r_line_vld, w_line_vld_n, w_used, w_exp;
  logic [KEY_W-1:0]          r_line_key [N_REMOTE_LINES];
  logic [KEY_W-1:0]          w_line_key_n [N_REMOTE_LINES];
  logic [AGE_W-1:0]          r_age [N_REMOTE_LINES];
  logic [AGE_W-1:0]          w_age_n [N_REMOTE_LINES];

  logic [N_PORTS-1:0] r_valid, r_pl, r_pr, r_ierr, r_ovf, r_byp, r_ign;
  logic [N_PORTS-1:0] w_valid, w_pl, w_pr, w_ierr, w_ovf, w_byp, w_ign;
  logic [N_PORTS-1:0] w_lreq, w_rreq, w_coll, w_lower;
  logic [SD_WIDTH-1:0] r_sd [N_PORTS];
  logic [SD_WIDTH-1:0] w_sd_n [N_PORTS];
  logic [KEY_W-1:0]    w_key [N_PORTS];
  logic                r_timeout, w_timeout, w_hit, w_found;
  logic [OCC_W-1:0]    r_occ, w_occ;

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      w_key[p]   = {level_i[p], id_i[p]};
      w_lreq[p]  = check_local_i[p] && !check_remote_i[p] && (int'(id_i[p]) < N_LOCAL_REGS);
      w_rreq[p]  = check_remote_i[p] && !check_local_i[p] && (EN_REMOTE != 0);
      w_ierr[p]  = check_local_i[p] && (check_remote_i[p] || (int'(id_i[p]) >= N_LOCAL_REGS));
      w_valid[p] = check_local_i[p] || (check_remote_i[p] && (EN_REMOTE != 0));
    end
  end

  // Collision groups: the lowest port of a shared key bypasses, the rest are ignored.
  always_comb begin
    w_coll  = '0;
    w_lower = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      for (int q = 0; q < N_PORTS; q++) begin
        if (q != p && ((w_lreq[p] && w_lreq[q] && id_i[p] == id_i[q]) ||
                       (w_rreq[p] && w_rreq[q] && w_key[p] == w_key[q]))) begin
          w_coll[p] = 1'b1;
          if (q < p) w_lower[p] = 1'b1;
        end
      end
    end
    w_byp = w_coll & ~w_lower;
    w_ign = w_coll & w_lower;
  end

  always_comb begin
    w_reg_vld_n  = r_reg_vld;
    w_reg_sd_n   = r_reg_sd;
    w_line_vld_n = r_line_vld;
    w_line_key_n = r_line_key;
    w_used       = r_line_vld;
    w_exp        = '0;
    w_pl         = '0;
    w_pr         = '0;
    w_ovf        = '0;
    w_hit        = 1'b0;
    w_found      = 1'b0;
    w_occ        = '0;
    for (int p = 0; p < N_PORTS; p++) w_sd_n[p] = '0;

    for (int l = 0; l < N_REMOTE_LINES; l++) begin
      w_age_n[l] = r_age[l];
      if (TIMEOUT_CYCLES > 0 && r_line_vld[l]) begin
        w_age_n[l] = r_age[l] + AGE_W'(1);
        if (r_age[l] == AGE_LAST) begin
          w_exp[l]        = 1'b1;
          w_line_vld_n[l] = 1'b0;
        end
      end
    end

    for (int p = 0; p < N_PORTS; p++) begin
      if (w_lreq[p] && !w_coll[p]) begin
        for (int r = 0; r < N_LOCAL_REGS; r++) begin
          if (int'(id_i[p]) == r) begin
            if (r_reg_vld[r]) begin
              w_pl[p]        = 1'b1;
              w_sd_n[p]      = r_reg_sd[r];
              w_reg_vld_n[r] = 1'b0;
            end else begin
              w_reg_vld_n[r] = 1'b1;
              w_reg_sd_n[r]  = sd_i[p];
            end
          end
        end
      end
    end

    // Allocation only draws on lines free at the start of the cycle, in port order.
    for (int p = 0; p < N_PORTS; p++) begin
      if (w_rreq[p] && !w_coll[p]) begin
        w_hit   = 1'b0;
        w_found = 1'b0;
        for (int l = 0; l < N_REMOTE_LINES; l++) begin
          if (r_line_vld[l] && r_line_key[l] == w_key[p]) begin
            w_hit           = 1'b1;
            w_pr[p]         = 1'b1;
            w_line_vld_n[l] = 1'b0;
            w_exp[l]        = 1'b0;
          end
        end
        if (!w_hit) begin
          for (int l = 0; l < N_REMOTE_LINES; l++) begin
            if (!w_found && !w_used[l]) begin
              w_found         = 1'b1;
              w_used[l]       = 1'b1;
              w_line_vld_n[l] = 1'b1;
              w_line_key_n[l] = w_key[p];
              w_age_n[l]      = '0;
            end
          end
          if (!w_found) w_ovf[p] = 1'b1;
        end
      end
    end

    for (int l = 0; l < N_REMOTE_LINES; l++) w_occ = w_occ + OCC_W'(w_line_vld_n[l]);
    w_timeout = |w_exp;
  end

  // Single registered stage: state update and per-port responses.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_reg_vld  <= '0;
      r_line_vld <= '0;
      r_valid    <= '0;
      r_pl       <= '0;
      r_pr       <= '0;
      r_ierr     <= '0;
      r_ovf      <= '0;
      r_byp      <= '0;
      r_ign      <= '0;
      r_timeout  <= 1'b0;
      r_occ      <= '0;
      for (int r = 0; r < N_LOCAL_REGS; r++) r_reg_sd[r] <= '0;
      for (int l = 0; l < N_REMOTE_LINES; l++) begin
        r_line_key[l] <= '0;
        r_age[l]      <= '0;
      end
      for (int p = 0; p < N_PORTS; p++) r_sd[p] <= '0;
    end else begin
      r_reg_vld  <= w_reg_vld_n;
      r_reg_sd   <= w_reg_sd_n;
      r_line_vld <= w_line_vld_n;
      r_line_key <= w_line_key_n;
      r_age      <= w_age_n;
      r_valid    <= w_valid;
      r_pl       <= w_pl;
      r_pr       <= w_pr;
      r_ierr     <= w_ierr;
      r_ovf      <= w_ovf;
      r_byp      <= w_byp;
      r_ign      <= w_ign;
      r_sd       <= w_sd_n;
      r_timeout  <= w_timeout;
      r_occ      <= w_occ;
    end
  end

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      valid_o[p]          = r_valid[p];
      present_local_o[p]  = r_pl[p];
      present_remote_o[p] = r_pr[p];
      sd_o[p]             = r_sd[p];
      id_err_o[p]         = r_ierr[p];
      ovf_err_o[p]        = r_ovf[p];
      bypass_o[p]         = r_byp[p];
      ignore_o[p]         = r_ign[p];
    end
    timeout_o    = r_timeout;
    remote_occ_o = r_occ;
  end

endmodule

// File: tb/tb_fractal_sync_nd_rf.sv
// Directed bench for fractal_sync_nd_rf: local/remote barriers, collisions,
// overflow, timeout, flush and reset, with hand-computed expectations.
module tb_fractal_sync_nd_rf;

  logic       clk_i = 1'b0;
  logic       rst_i, flush_i;
  logic [1:0] level_i [4];
  logic [2:0] id_i [4];
  logic       check_local_i [4];
  logic       check_remote_i [4];
  logic [1:0] sd_i [4];
  logic       valid_o [4];
  logic       present_local_o [4];
  logic       present_remote_o [4];
  logic [1:0] sd_o [4];
  logic       id_err_o [4];
  logic       ovf_err_o [4];
  logic       bypass_o [4];
  logic       ignore_o [4];
  logic       timeout_o;
  logic [2:0] remote_occ_o;

  logic [3:0] v_vld, v_pl, v_pr, v_err, v_ovf, v_byp, v_ign;
  int n_chk = 0;
  int n_pass = 0;

  fractal_sync_nd_rf #(
    .N_PORTS(4), .N_LOCAL_REGS(4), .N_REMOTE_LINES(4), .LEVEL_WIDTH(2),
    .ID_WIDTH(3), .SD_WIDTH(2), .EN_REMOTE(1), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .level_i(level_i), .id_i(id_i),
    .check_local_i(check_local_i), .check_remote_i(check_remote_i),
    .sd_i(sd_i), .valid_o(valid_o),
    .present_local_o(present_local_o), .present_remote_o(present_remote_o),
    .sd_o(sd_o), .id_err_o(id_err_o), .ovf_err_o(ovf_err_o),
    .bypass_o(bypass_o), .ignore_o(ignore_o),
    .timeout_o(timeout_o), .remote_occ_o(remote_occ_o)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    v_vld = '0; v_pl = '0; v_pr = '0; v_err = '0; v_ovf = '0; v_byp = '0; v_ign = '0;
    for (int i = 0; i < 4; i++) begin
      v_vld[i] = valid_o[i];
      v_pl[i]  = present_local_o[i];
      v_pr[i]  = present_remote_o[i];
      v_err[i] = id_err_o[i];
      v_ovf[i] = ovf_err_o[i];
      v_byp[i] = bypass_o[i];
      v_ign[i] = ignore_o[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic clr();
    flush_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_local_i[i] = 1'b0; check_remote_i[i] = 1'b0;
      level_i[i] = '0; id_i[i] = '0; sd_i[i] = '0;
    end
  endtask

  task automatic loc(input int p, input logic [2:0] id, input logic [1:0] sd);
    check_local_i[p] = 1'b1; id_i[p] = id; sd_i[p] = sd;
  endtask

  task automatic rem(input int p, input logic [1:0] lvl, input logic [2:0] id);
    check_remote_i[p] = 1'b1; level_i[p] = lvl; id_i[p] = id;
  endtask

  // Inputs take effect at the next rising edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
    clr();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    chk("rst_valid", v_vld, 4'b0000);
    chk("rst_occ", remote_occ_o, 3'd0);
    chk("rst_timeout", timeout_o, 1'b0);

    // Local barrier on id 1: arrival then completion returns stored sources.
    loc(0, 3'd1, 2'b01); tick();
    chk("l_arrive_valid", v_vld, 4'b0001);
    chk("l_arrive_pl", v_pl, 4'b0000);
    loc(1, 3'd1, 2'b11); tick();
    chk("l_done_valid", v_vld, 4'b0010);
    chk("l_done_pl", v_pl, 4'b0010);
    chk("l_done_sd", sd_o[1], 2'b01);
    loc(2, 3'd1, 2'b10); tick();
    chk("l_cleared_pl", v_pl, 4'b0000);
    loc(3, 3'd1, 2'b00); tick();
    chk("l_reuse_pl", v_pl, 4'b1000);
    chk("l_reuse_sd", sd_o[3], 2'b10);

    // Local collision on id 2 leaves the register untouched.
    loc(0, 3'd2, 2'b01); loc(2, 3'd2, 2'b10); tick();
    chk("lcol_valid", v_vld, 4'b0101);
    chk("lcol_byp", v_byp, 4'b0001);
    chk("lcol_ign", v_ign, 4'b0100);
    chk("lcol_pl", v_pl, 4'b0000);
    loc(1, 3'd2, 2'b11); tick();
    chk("lcol_after_pl", v_pl, 4'b0000);
    loc(0, 3'd2, 2'b00); tick();
    chk("lcol_done_pl", v_pl, 4'b0001);
    chk("lcol_done_sd", sd_o[0], 2'b11);

    // Remote collision on {1,3}.
    rem(0, 2'd1, 3'd3); rem(2, 2'd1, 3'd3); tick();
    chk("rcol_byp", v_byp, 4'b0001);
    chk("rcol_ign", v_ign, 4'b0100);
    chk("rcol_occ", remote_occ_o, 3'd0);
    chk("rcol_pr", v_pr, 4'b0000);

    // Fill the CAM, overflow, hit, reuse, then flush with 3 lines valid.
    rem(0, 2'd0, 3'd0); rem(1, 2'd0, 3'd1); rem(2, 2'd0, 3'd2); tick();
    chk("fill_occ3", remote_occ_o, 3'd3);
    chk("fill_ovf0", v_ovf, 4'b0000);
    rem(0, 2'd1, 3'd0); rem(1, 2'd1, 3'd1); tick();
    chk("fill_occ4", remote_occ_o, 3'd4);
    chk("fill_ovf", v_ovf, 4'b0010);
    rem(3, 2'd0, 3'd1); tick();
    chk("hit_pr", v_pr, 4'b1000);
    chk("hit_occ", remote_occ_o, 3'd3);
    rem(0, 2'd2, 3'd2); tick();
    chk("reuse_ovf", v_ovf, 4'b0000);
    chk("reuse_occ", remote_occ_o, 3'd4);
    rem(1, 2'd0, 3'd0); tick();
    chk("hit2_pr", v_pr, 4'b0010);
    chk("hit2_occ", remote_occ_o, 3'd3);
    flush_i = 1'b1; loc(0, 3'd3, 2'b01); rem(2, 2'd1, 3'd2); tick();
    chk("flush_valid", v_vld, 4'b0000);
    chk("flush_occ", remote_occ_o, 3'd0);
    loc(1, 3'd3, 2'b10); rem(0, 2'd1, 3'd0); tick();
    chk("flush_drop_pl", v_pl, 4'b0000);
    chk("flush_clr_pr", v_pr, 4'b0000);
    chk("flush_clr_occ", remote_occ_o, 3'd1);
    flush_i = 1'b1; tick();

    // Id errors: out-of-range id and both strobes high.
    loc(0, 3'd5, 2'b01); loc(2, 3'd1, 2'b10); rem(2, 2'd1, 3'd1); tick();
    chk("err_bits", v_err, 4'b0101);
    chk("err_valid", v_vld, 4'b0101);
    chk("err_occ", remote_occ_o, 3'd0);
    loc(0, 3'd1, 2'b01); tick();
    chk("err_nostate_pl", v_pl, 4'b0000);
    flush_i = 1'b1; tick();

    // Timeout: a lone line expires 8 cycles after allocation.
    rem(0, 2'd2, 3'd1); tick();
    chk("to_alloc_occ", remote_occ_o, 3'd1);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("to_wait_timeout", timeout_o, 1'b0);
    end
    tick();
    chk("to_pulse", timeout_o, 1'b1);
    chk("to_occ", remote_occ_o, 3'd0);
    tick();
    chk("to_end", timeout_o, 1'b0);

    // A hit on the expiry cycle wins.
    rem(1, 2'd3, 3'd3); tick();
    for (int k = 1; k < 8; k++) tick();
    rem(2, 2'd3, 3'd3); tick();
    chk("tohit_pr", v_pr, 4'b0100);
    chk("tohit_timeout", timeout_o, 1'b0);
    chk("tohit_occ", remote_occ_o, 3'd0);

    // Reset the cycle after a check.
    rem(0, 2'd0, 3'd3); loc(1, 3'd0, 2'b01); tick();
    chk("pre_rst_valid", v_vld, 4'b0011);
    rst_i = 1'b1; loc(2, 3'd0, 2'b10); tick();
    rst_i = 1'b0;
    chk("mid_rst_valid", v_vld, 4'b0000);
    chk("mid_rst_occ", remote_occ_o, 3'd0);
    loc(1, 3'd0, 2'b11); rem(0, 2'd0, 3'd3); tick();
    chk("post_rst_pl", v_pl, 4'b0000);
    chk("post_rst_pr", v_pr, 4'b0000);
    chk("post_rst_occ", remote_occ_o, 3'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
